led_strip_controller: RTL

LED_STRIP_CONTROLLER -- requirements
Module: led_strip_controller

---
 rtl/led_strip_controller.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/led_strip_controller.sv
// Two-wire (clock + data) LED strip driver: streams LED_COUNT 24-bit pixels MSB first,
// then holds the line idle long enough for the strip to latch the new colours.
module led_strip_controller #(
    parameter int LED_COUNT    = 5,
    parameter int CLK_DIV      = 4,
    parameter int LATCH_CYCLES = 26000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        sclk,
    output logic        sdo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    localparam int PCW = $clog2(LED_COUNT + 1);
    localparam int DCW = $clog2(CLK_DIV + 1);
    localparam int LCW = $clog2(LATCH_CYCLES + 1);

    localparam logic [PCW-1:0] PIX_LAST   = PCW'(LED_COUNT - 1);
    localparam logic [DCW-1:0] DIV_LAST   = DCW'(CLK_DIV - 1);
    localparam logic [LCW-1:0] LATCH_LAST = LCW'(LATCH_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t           state_r;
    logic [23:0]      shift_r;
    logic [4:0]       bit_cnt_r;
    logic [DCW-1:0]   div_cnt_r;
    logic             high_r;
    logic [PCW-1:0]   pix_cnt_r;
    logic [LCW-1:0]   latch_cnt_r;
    logic             sclk_r;
    logic             sdo_r;
    logic             pix_ready_r;
    logic             busy_r;
    logic             done_r;

    // Frame sequencer; every serial-line and handshake output is a flop updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            shift_r     <= 24'd0;
            bit_cnt_r   <= 5'd0;
            div_cnt_r   <= {DCW{1'b0}};
            high_r      <= 1'b0;
            pix_cnt_r   <= {PCW{1'b0}};
            latch_cnt_r <= {LCW{1'b0}};
            sclk_r      <= 1'b0;
            sdo_r       <= 1'b0;
            pix_ready_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= ST_LOAD;
                        pix_cnt_r   <= {PCW{1'b0}};
                        busy_r      <= 1'b1;
                        pix_ready_r <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // sdo is presented with the first bit at the same edge the low phase begins
                    if (pix_valid) begin
                        shift_r     <= pix_data;
                        sdo_r       <= pix_data[23];
                        bit_cnt_r   <= 5'd23;
                        div_cnt_r   <= {DCW{1'b0}};
                        high_r      <= 1'b0;
                        pix_ready_r <= 1'b0;
                        state_r     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (div_cnt_r == DIV_LAST) begin
                        div_cnt_r <= {DCW{1'b0}};
                        if (!high_r) begin
                            high_r <= 1'b1;
                            sclk_r <= 1'b1;
                        end else begin
                            high_r <= 1'b0;
                            sclk_r <= 1'b0;
                            if (bit_cnt_r == 5'd0) begin
                                pix_cnt_r <= pix_cnt_r + PCW'(1);
                                sdo_r     <= 1'b0;
                                if (pix_cnt_r == PIX_LAST) begin
                                    latch_cnt_r <= {LCW{1'b0}};
                                    state_r     <= ST_LATCH;
                                end else begin
                                    pix_ready_r <= 1'b1;
                                    state_r     <= ST_LOAD;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r - 5'd1;
                                shift_r   <= {shift_r[22:0], 1'b0};
                                sdo_r     <= shift_r[22];
                            end
                        end
                    end else begin
                        div_cnt_r <= div_cnt_r + DCW'(1);
                    end
                end
                ST_LATCH: begin
                    if (latch_cnt_r == LATCH_LAST) begin
                        done_r  <= 1'b1;
                        state_r <= ST_DONE;
                    end else begin
                        latch_cnt_r <= latch_cnt_r + LCW'(1);
                    end
                end
                ST_DONE: begin
                    // start is deliberately not sampled here; a new frame begins only from IDLE
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    sclk_r      <= 1'b0;
                    sdo_r       <= 1'b0;
                    pix_ready_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                end
            endcase
        end
    end

    assign pix_ready = pix_ready_r;
    assign sclk      = sclk_r;
    assign sdo       = sdo_r;
    assign busy      = busy_r;
    assign done      = done_r;
    // Stall must track pix_valid within the same LOAD cycle, so it is decoded from state flops.
    assign stall     = (state_r == ST_LOAD) && !pix_valid && (pix_cnt_r != {PCW{1'b0}});

endmodule
